interrupt_ctrl: RTL and testbench

//  Interrupt front end feeding the hmc-6502 core's sequencing and branch logic.

---
 rtl/interrupt_ctrl_pkg.sv | 29 ++
 rtl/interrupt_ctrl_pin_sync.sv | 24 ++
 rtl/interrupt_ctrl.sv | 124 ++++++++++++
 tb/tb_interrupt_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and constants for the hmc-6502 interrupt front end.
package hmc6502_int_pkg;

  typedef enum logic [1:0] {
    K_IRQ   = 2'd0,
    K_NMI   = 2'd1,
    K_RESET = 2'd2,
    K_BRK   = 2'd3
  } int_kind_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SERV = 1'b1
  } state_t;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  // BRK shares the IRQ vector; the pushed B flag is what distinguishes them.
  function automatic logic [15:0] vector_of(input int_kind_t kind);
    case (kind)
      K_NMI:   return VEC_NMI;
      K_RESET: return VEC_RESET;
      default: return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_ctrl_pin_sync.sv
// Multi-flop synchroniser for an asynchronous, active-low pin.
module pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic pin_s
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the pin through the chain; reset to the inactive (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
    end
  end

  assign pin_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt front end: pin sync, NMI edge detect, RESET>NMI>IRQ/BRK arbitration,
// vector and B-flag supply for the hmc-6502 interrupt sequence.
module interrupt_ctrl
  import hmc6502_int_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_b,
  input  logic        irq_b,
  input  logic        i_flag,
  input  logic        instr_bound,
  input  logic        brk_start,
  input  logic        int_ack,
  input  logic        int_done,
  output logic        int_req,
  output logic [1:0]  int_kind,
  output logic [15:0] vector_addr,
  output logic        b_flag,
  output logic        in_service
);

  logic      nmi_s;
  logic      irq_s;
  logic      nmi_s_prev;
  logic      nmi_fall;
  logic      nmi_pend;
  logic      reset_pend;
  logic      irq_act;
  int_kind_t kind_q;
  int_kind_t hw_kind;
  state_t    state;

  // The core only samples int_req at instr_bound; arbitration here is
  // continuous, so the strobe carries no information for this block.
  logic unused_inputs;
  assign unused_inputs = instr_bound;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (nmi_b),
    .pin_s (nmi_s)
  );

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (irq_b),
    .pin_s (irq_s)
  );

  assign nmi_fall = nmi_s_prev & ~nmi_s;
  assign irq_act  = ~irq_s & ~i_flag;
  assign int_req  = (state == S_IDLE) & (reset_pend | nmi_pend | irq_act);

  // Highest-priority hardware source currently pending.
  always_comb begin
    hw_kind = K_IRQ;
    if (reset_pend) begin
      hw_kind = K_RESET;
    end else if (nmi_pend) begin
      hw_kind = K_NMI;
    end
  end

  // Service FSM with registered kind, vector and B flag; NMI edge capture.
  // The NMI set is written last so it overrides a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      nmi_s_prev  <= 1'b1;
      nmi_pend    <= 1'b0;
      reset_pend  <= 1'b1;
      kind_q      <= K_RESET;
      vector_addr <= VEC_RESET;
      b_flag      <= 1'b0;
    end else begin
      nmi_s_prev <= nmi_s;
      case (state)
        S_IDLE: begin
          if (int_ack) begin
            if (int_req) begin
              state       <= S_SERV;
              kind_q      <= hw_kind;
              vector_addr <= vector_of(hw_kind);
              b_flag      <= 1'b0;
              if (hw_kind == K_RESET) begin
                reset_pend <= 1'b0;
              end else if (hw_kind == K_NMI) begin
                nmi_pend <= 1'b0;
              end
            end
          end else if (brk_start) begin
            state  <= S_SERV;
            b_flag <= 1'b1;
            if (nmi_pend) begin
              kind_q      <= K_NMI;
              vector_addr <= VEC_NMI;
              nmi_pend    <= 1'b0;
            end else begin
              kind_q      <= K_BRK;
              vector_addr <= VEC_IRQ;
            end
          end
        end
        S_SERV: begin
          if (int_done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (nmi_fall) begin
        nmi_pend <= 1'b1;
      end
    end
  end

  assign in_service = (state == S_SERV);
  assign int_kind   = kind_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboard bench for interrupt_ctrl: directed scenarios then random traffic,
// all checked against a behavioural model of the interrupt rules.
module tb_interrupt_ctrl;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nmi_b = 1'b1;
  logic        irq_b = 1'b1;
  logic        i_flag = 1'b1;
  logic        instr_bound = 1'b0;
  logic        brk_start = 1'b0;
  logic        int_ack = 1'b0;
  logic        int_done = 1'b0;
  logic        int_req;
  logic [1:0]  int_kind;
  logic [15:0] vector_addr;
  logic        b_flag;
  logic        in_service;

  always #5 clk = ~clk;

  interrupt_ctrl #(.SYNC_STAGES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .nmi_b       (nmi_b),
    .irq_b       (irq_b),
    .i_flag      (i_flag),
    .instr_bound (instr_bound),
    .brk_start   (brk_start),
    .int_ack     (int_ack),
    .int_done    (int_done),
    .int_req     (int_req),
    .int_kind    (int_kind),
    .vector_addr (vector_addr),
    .b_flag      (b_flag),
    .in_service  (in_service)
  );

  typedef struct {
    logic        req;
    logic        serv;
    logic [1:0]  kind;
    logic [15:0] vec;
    logic        b;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: kinds 0=IRQ 1=NMI 2=RESET 3=BRK.
  bit m_pr, m_pn, m_serv, m_b;
  int m_kind;
  bit nh[$];
  bit ih[$];
  bit nl = 1'b1, il = 1'b1, fl = 1'b1;

  function automatic logic [15:0] vec_model(input int k);
    if (k == 1) return 16'hFFFA;
    if (k == 2) return 16'hFFFC;
    return 16'hFFFE;
  endfunction

  // Pin value seen S posedges ago is the synchronised level.
  function automatic bit m_req();
    bit irq_on;
    irq_on = (ih[S-1] == 1'b0) && !i_flag;
    return !m_serv && (m_pr || m_pn || irq_on);
  endfunction

  task automatic model_edge();
    bit edge_seen;
    bit req;
    if (reset) begin
      m_pr = 1; m_pn = 0; m_serv = 0; m_kind = 2; m_b = 0;
      nh.delete(); ih.delete();
      repeat (S + 1) begin nh.push_back(1'b1); ih.push_back(1'b1); end
    end else begin
      edge_seen = nh[S] && !nh[S-1];
      req = m_req();
      if (!m_serv) begin
        if (int_ack) begin
          if (req) begin
            m_serv = 1; m_b = 0;
            if (m_pr) begin m_kind = 2; m_pr = 0; end
            else if (m_pn) begin m_kind = 1; m_pn = 0; end
            else m_kind = 0;
          end
        end else if (brk_start) begin
          m_serv = 1; m_b = 1;
          if (m_pn) begin m_kind = 1; m_pn = 0; end
          else m_kind = 3;
        end
      end else if (int_done) begin
        m_serv = 0;
      end
      if (edge_seen) m_pn = 1;
      nh.push_front(nmi_b); void'(nh.pop_back());
      ih.push_front(irq_b); void'(ih.pop_back());
    end
  endtask

  task automatic step(input bit rst, input bit ack, input bit brk, input bit done);
    exp_t x;
    @(posedge clk);
    model_edge();
    #1;
    reset = rst; int_ack = ack; brk_start = brk; int_done = done;
    nmi_b = nl; irq_b = il; i_flag = fl;
    instr_bound = 1'($urandom_range(1));
    x.req  = m_req();
    x.serv = m_serv;
    x.kind = 2'(m_kind);
    x.vec  = vec_model(m_kind);
    x.b    = m_b;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("int_req", 16'(int_req), 16'(e.req));
      chk("in_service", 16'(in_service), 16'(e.serv));
      chk("int_kind", 16'(int_kind), 16'(e.kind));
      chk("vector_addr", vector_addr, e.vec);
      chk("b_flag", 16'(b_flag), 16'(e.b));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit a, b, d, r;
    // Reset, then service the reset request.
    repeat (3) step(1, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0); idle(2); step(0, 0, 0, 1); idle(3);
    // NMI falling edge, pin held low.
    nl = 0; idle(10);
    step(0, 1, 0, 0); idle(1); step(0, 0, 0, 1); idle(3);
    nl = 1; idle(4);
    // IRQ masked, unmasked, then withdrawn before ack.
    il = 0; idle(4); fl = 0; idle(3); il = 1; idle(4);
    // IRQ and NMI together: NMI first, IRQ afterwards.
    il = 0; nl = 0; idle(5);
    step(0, 1, 0, 0); idle(1); step(0, 0, 0, 1); idle(2);
    step(0, 1, 0, 0); idle(1); il = 1; step(0, 0, 0, 1);
    nl = 1; fl = 1; idle(4);
    // BRK hijacked by a pending NMI.
    nl = 0; idle(5); step(0, 0, 1, 0); idle(1); step(0, 0, 0, 1);
    nl = 1; idle(4);
    // Plain BRK with an NMI edge arriving during service, then reset mid-service.
    step(0, 0, 1, 0); nl = 0; idle(5); step(0, 0, 0, 1); idle(2);
    step(0, 1, 0, 0); idle(2); step(1, 0, 0, 0); nl = 1; idle(4);
    // Protocol error: ack without a request, plus ack/brk collision.
    step(0, 1, 0, 0); idle(1); step(0, 1, 0, 0); idle(1); step(0, 0, 0, 1); idle(2);
    step(0, 1, 1, 0); idle(2);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) nl = ~nl;
      if ($urandom_range(5) == 0) il = ~il;
      if ($urandom_range(9) == 0) fl = ~fl;
      r = ($urandom_range(199) == 0);
      if (m_serv) a = ($urandom_range(19) == 0);
      else if (m_req()) a = ($urandom_range(2) == 0);
      else a = ($urandom_range(29) == 0);
      b = ($urandom_range(11) == 0);
      d = m_serv ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
      step(r, a, b, d);
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
